// File: rtl/pw_trigger_gen.sv
// Programmable multi-pulse trigger generator: a match starts a sequence of up to
// pNUM_TRIGGER_PULSES delay/width slots, with abort on enable drop.
module pw_trigger_gen #(
  parameter int pNUM_TRIGGER_PULSES = 8,
  parameter int pNUM_TRIGGER_WIDTH  = 4,
  parameter int pTRIG_FIELD_WIDTH   = 24
) (
  input  logic                                          fe_clk,
  input  logic                                          reset_i,
  input  logic                                          I_match,
  input  logic                                          I_trigger_enable,
  input  logic [pNUM_TRIGGER_WIDTH-1:0]                 I_num_triggers,
  input  logic [pTRIG_FIELD_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_delay,
  input  logic [pTRIG_FIELD_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_width,
  output logic                                          O_trigger,
  output logic                                          O_busy,
  output logic                                          O_done,
  output logic [pNUM_TRIGGER_WIDTH-1:0]                 O_pulse_index
);
  localparam int NP = pNUM_TRIGGER_PULSES;
  localparam int NW = pNUM_TRIGGER_WIDTH;
  localparam int FW = pTRIG_FIELD_WIDTH;

  typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] cnt, cnt_nxt;
  logic [NW-1:0] idx, idx_nxt;
  logic          trig, trig_nxt;
  logic          done, done_nxt;

  logic [31:0]   num32, eff;
  logic          last;
  logic [NW-1:0] sel_idx;
  logic [FW-1:0] d_sel, w_sel, w_load;

  // Slot fields are fetched for the slot about to start: the next slot while in PULSE.
  always_comb begin
    num32   = 32'(I_num_triggers);
    eff     = (num32 > 32'(NP)) ? 32'(NP) : num32;
    last    = ((32'(idx) + 32'd1) == eff);
    sel_idx = (state == PULSE) ? idx + NW'(1) : idx;
    d_sel   = '0;
    w_sel   = '0;
    for (int i = 0; i < NP; i++) begin
      if (i == int'(sel_idx)) begin
        d_sel = I_trigger_delay[i*FW +: FW];
        w_sel = I_trigger_width[i*FW +: FW];
      end
    end
    w_load  = (w_sel == '0) ? '0 : w_sel - FW'(1);
  end

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      trig  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      trig  <= trig_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    trig_nxt  = trig;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        trig_nxt = 1'b0;
        idx_nxt  = '0;
        cnt_nxt  = '0;
        if (I_match && I_trigger_enable && (eff != 32'd0)) begin
          // The IDLE->DELAY edge itself provides one low cycle, so d0 loads unmodified.
          state_nxt = DELAY;
          cnt_nxt   = d_sel;
        end
      end
      DELAY: begin
        if (!I_trigger_enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          trig_nxt  = 1'b0;
        end else if (cnt == '0) begin
          state_nxt = PULSE;
          cnt_nxt   = w_load;
          trig_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - FW'(1);
        end
      end
      PULSE: begin
        if (!I_trigger_enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          trig_nxt  = 1'b0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - FW'(1);
        end else if (last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          trig_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt = idx + NW'(1);
          if (d_sel == '0) begin
            state_nxt = PULSE;
            cnt_nxt   = w_load;
            trig_nxt  = 1'b1;
          end else begin
            state_nxt = DELAY;
            cnt_nxt   = d_sel - FW'(1);
            trig_nxt  = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
        trig_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    O_trigger     = trig;
    O_busy        = (state != IDLE);
    O_done        = done;
    O_pulse_index = idx;
  end
endmodule

// File: doc/pw_trigger_gen.md
PW_TRIGGER_GEN -- requirements
Module: pw_trigger_gen

Interface
REQ-001 The block SHALL take parameter pNUM_TRIGGER_PULSES, default 8: number of programmable pulse slots.
REQ-002 The block SHALL take parameter pNUM_TRIGGER_WIDTH, default 4: width of the pulse-count input.
REQ-003 The block SHALL take parameter pTRIG_FIELD_WIDTH, default 24: width of each per-pulse delay and width field.
REQ-004 The block SHALL have port fe_clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port I_match, input, 1 bit: single-cycle pattern-match pulse from front-end capture.
REQ-007 The block SHALL have port I_trigger_enable, input, 1 bit: master enable.
REQ-008 The block SHALL have port I_num_triggers, input, pNUM_TRIGGER_WIDTH bits: number of pulses per sequence.
REQ-009 The block SHALL have port I_trigger_delay, input, pTRIG_FIELD_WIDTH*pNUM_TRIGGER_PULSES bits: slot i is bits [i*pTRIG_FIELD_WIDTH +: pTRIG_FIELD_WIDTH].
REQ-010 The block SHALL have port I_trigger_width, input, pTRIG_FIELD_WIDTH*pNUM_TRIGGER_PULSES bits: slot i packed the same way as I_trigger_delay.
REQ-011 The block SHALL have port O_trigger, output, 1 bit: registered trigger output.
REQ-012 The block SHALL have port O_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have port O_done, output, 1 bit: one-cycle pulse at the normal end of a sequence.
REQ-014 The block SHALL have port O_pulse_index, output, pNUM_TRIGGER_WIDTH bits: index of the slot currently being processed.

Function
REQ-015 The state machine SHALL have exactly three states: IDLE, DELAY and PULSE.
REQ-016 In IDLE, when I_match=1, I_trigger_enable=1 and the effective count is nonzero, the block SHALL clear the index to 0, load the delay counter with slot 0 delay and enter DELAY on the next edge.
REQ-017 The effective count SHALL be min(I_num_triggers, pNUM_TRIGGER_PULSES).
REQ-018 An effective count of 0 SHALL cause I_match to be ignored.
REQ-019 Timing: with I_match sampled at edge N, O_trigger SHALL first be high in the cycle following edge N+1+d0, where d0 is the slot 0 delay; d0=0 gives a rise at edge N+1.
REQ-020 PULSE SHALL hold O_trigger=1 for exactly max(w_i,1) cycles, where w_i is the width of slot i; a width of 0 is treated as 1.
REQ-021 After PULSE for slot i, if i+1 equals the effective count, the block SHALL return to IDLE, with O_trigger low and O_done high in the same cycle, for one cycle.
REQ-022 Otherwise the block SHALL increment the index and enter DELAY for d_(i+1) low cycles before the next PULSE.
REQ-023 If d_(i+1)=0, the next PULSE SHALL follow immediately with no low gap, so O_trigger stays high.
REQ-024 Each slot's delay and width SHALL be sampled when its DELAY or PULSE phase is entered; later changes to the inputs SHALL NOT affect a phase already in progress.
REQ-025 Counters SHALL be pTRIG_FIELD_WIDTH bits, down-counting to 0, with no wrap.
REQ-026 A maximum field value SHALL give exactly 2^pTRIG_FIELD_WIDTH-1 cycles.
REQ-027 I_match while O_busy=1 SHALL be ignored; there is no queuing or retrigger.
REQ-028 I_trigger_enable=0 in DELAY or PULSE SHALL abort the sequence: on the next edge the state is IDLE, O_trigger=0, index=0, and O_done stays 0.
REQ-029 If I_match and I_trigger_enable deassertion occur in the same cycle in IDLE, the block SHALL NOT start a sequence.
REQ-030 O_pulse_index SHALL equal the current slot during DELAY and PULSE, and 0 in IDLE.

Reset
REQ-031 reset_i=1 at any edge, including mid-sequence, SHALL force IDLE with O_trigger=0, O_busy=0, O_done=0, O_pulse_index=0, and all counters cleared.
REQ-032 I_match asserted during reset, or in the same cycle as reset, SHALL be ignored.
REQ-033 The first sequence SHALL be able to start on the first edge after reset_i falls.

Verification
REQ-034 The bench SHALL check: count=1, d0=5, w0=3, I_match at edge 10 -> O_trigger high after edges 16-18, low after edge 19, O_done high after edge 19 only.
REQ-035 The bench SHALL check: count=3, d=(0,2,0), w=(1,1,2) -> trigger pattern 1,0,0,1,1,1 starting after edge N+1, then O_done; O_pulse_index steps 0,1,2.
REQ-036 The bench SHALL check: count=0, or I_trigger_enable=0, with I_match pulsed -> O_busy and O_trigger stay 0.
REQ-037 The bench SHALL check: count=12 with pNUM_TRIGGER_PULSES=8 -> exactly 8 pulses, then O_done.
REQ-038 The bench SHALL check: a second I_match during the DELAY of slot 0, and I_trigger_enable dropped during a PULSE -> the second match has no effect; the abort gives O_trigger=0 after the next edge and no O_done.
REQ-039 The bench SHALL check: reset_i asserted for 1 cycle in the middle of a width-100 pulse -> O_trigger=0 and O_busy=0 after that edge; a new I_match restarts from slot 0.
